// File: rtl/timer_bank.sv
`default_nettype none
// ============================================================================
// Module   : timer_bank
// Purpose  : NCH independent interval timers driven by one shared prescaler.
//            Each channel has a loadable terminal count, one-shot or periodic
//            mode, a run/pause enable, a one-cycle expiry pulse and a sticky
//            status flag. irq is the OR of all status flags.
// Ports    : clk        - clock, rising edge
//            reset      - asynchronous active-high reset
//            prescale   - tick every prescale+1 cycles
//            en         - per-channel run enable (level)
//            periodic   - per-channel auto-reload select
//            load       - per-channel load strobe (tc <= slice, back to IDLE)
//            load_value - channel i in bits [i*CW +: CW]
//            clr        - per-channel status clear strobe
//            count      - current count of each channel (i*CW +: CW)
//            pulse      - registered one-cycle expiry pulse
//            done       - one-shot channel parked at terminal count
//            status     - sticky expiry flags
//            irq        - OR of status (combinational)
// Revision : 1.0 - initial release
// ============================================================================
module timer_bank #(
  parameter int NCH        = 4,
  parameter int CW         = 16,
  parameter int PSW        = 8,
  parameter int DEFAULT_TC = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PSW-1:0]    prescale,
  input  logic [NCH-1:0]    en,
  input  logic [NCH-1:0]    periodic,
  input  logic [NCH-1:0]    load,
  input  logic [NCH*CW-1:0] load_value,
  input  logic [NCH-1:0]    clr,
  output logic [NCH*CW-1:0] count,
  output logic [NCH-1:0]    pulse,
  output logic [NCH-1:0]    done,
  output logic [NCH-1:0]    status,
  output logic              irq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Shared prescaler. Using >= rather than == means lowering prescale below
  // the current pre_cnt gives an immediate tick instead of a wrap.
  // --------------------------------------------------------------------------
  logic [PSW-1:0] pre_cnt;
  logic           tick;

  assign tick = (pre_cnt >= prescale);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PSW'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Per-channel timer
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] tc_q, tc_d;
    logic          expire;
    logic          pulse_q;
    logic          status_q;

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tc_d    = tc_q;
      expire  = 1'b0;
      if (load[i]) begin
        // Load pre-empts everything, including an expiry in the same cycle.
        tc_d    = load_value[i*CW +: CW];
        cnt_d   = '0;
        state_d = S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            cnt_d = '0;
            // Arming edge only; the first count is taken on a later tick.
            if (en[i]) state_d = S_RUN;
          end
          S_RUN: begin
            if (en[i] && tick) begin
              if (cnt_q >= tc_q) begin
                expire = 1'b1;
                // Mode is sampled here, so periodic changes apply at expiry.
                if (periodic[i]) begin
                  cnt_d = '0;
                end else begin
                  cnt_d   = tc_q;
                  state_d = S_DONE;
                end
              end else begin
                cnt_d = cnt_q + CW'(1);
              end
            end
          end
          S_DONE: begin
            cnt_d = tc_q;
            if (!en[i]) begin
              cnt_d   = '0;
              state_d = S_IDLE;
            end
          end
          default: begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end
        endcase
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q  <= S_IDLE;
        cnt_q    <= '0;
        tc_q     <= CW'(DEFAULT_TC);
        pulse_q  <= 1'b0;
        status_q <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        tc_q    <= tc_d;
        pulse_q <= expire;
        // Set has priority over clear.
        if (expire) begin
          status_q <= 1'b1;
        end else if (clr[i]) begin
          status_q <= 1'b0;
        end
      end
    end

    assign count[i*CW +: CW] = cnt_q;
    assign pulse[i]          = pulse_q;
    assign done[i]           = (state_q == S_DONE);
    assign status[i]         = status_q;
  end

  assign irq = |status;

endmodule
`default_nettype wire

// File: tb/tb_timer_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_timer_bank
// Purpose  : Self-checking bench for timer_bank. Expected pulse cycles are
//            queued per channel when stimulus is applied and matched against
//            observed pulses by a monitor; counts/flags are checked inline.
// Revision : 1.0 - initial release
// ============================================================================
module tb_timer_bank;
  localparam int NCH = 4;
  localparam int CW  = 16;
  localparam int PSW = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [PSW-1:0]    prescale;
  logic [NCH-1:0]    en, periodic, load, clr;
  logic [NCH*CW-1:0] load_value;
  logic [NCH*CW-1:0] count;
  logic [NCH-1:0]    pulse, done, status;
  logic              irq;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int exp_q [NCH][$];

  timer_bank #(.NCH(NCH), .CW(CW), .PSW(PSW), .DEFAULT_TC(7)) dut (
    .clk(clk), .reset(reset), .prescale(prescale), .en(en),
    .periodic(periodic), .load(load), .load_value(load_value), .clr(clr),
    .count(count), .pulse(pulse), .done(done), .status(status), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [CW-1:0] cnt_of(input int c);
    return count[c*CW +: CW];
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic do_load(input int c, input int v);
    load_value[c*CW +: CW] = CW'(v);
    load[c] = 1'b1;
    step(1);
    load[c] = 1'b0;
  endtask

  task automatic clr_ch(input int c);
    clr[c] = 1'b1;
    step(1);
    clr[c] = 1'b0;
    check_val($sformatf("status_cleared_ch%0d", c), status[c], 1'b0);
  endtask

  // Pulse monitor: every observed pulse must match the head of its queue.
  always @(negedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (pulse[c] === 1'b1) begin
        if (exp_q[c].size() == 0) begin
          check_val($sformatf("unexpected_pulse_ch%0d", c), pulse[c], 1'b0);
        end else begin
          int e;
          e = exp_q[c].pop_front();
          check_val($sformatf("pulse_cycle_ch%0d", c), cyc, e);
        end
      end else if (exp_q[c].size() > 0 && exp_q[c][0] <= cyc) begin
        void'(exp_q[c].pop_front());
        check_val($sformatf("missed_pulse_ch%0d", c), pulse[c], 1'b1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int seq [6];
    reset = 1'b1; prescale = '0; en = '0; periodic = '0; load = '0; clr = '0;
    load_value = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_val("rst_count", count, '0);
    check_val("rst_pulse", pulse, '0);
    check_val("rst_done", done, '0);
    check_val("rst_status", status, '0);
    check_val("rst_irq", irq, 1'b0);

    // 1: default tc=7 one-shot, pulse tc+2 cycles after en sampled
    n = cyc; en[0] = 1'b1;
    exp_q[0].push_back(n + 9);
    run_to(n + 10);
    check_val("t1_done", done[0], 1'b1);
    check_val("t1_count", cnt_of(0), 16'd7);
    check_val("t1_status", status[0], 1'b1);
    en[0] = 1'b0;
    step(1);
    check_val("t1_count_idle", cnt_of(0), 16'd0);
    check_val("t1_done_idle", done[0], 1'b0);
    clr_ch(0);

    // 2: tc=3 one-shot
    do_load(0, 3);
    n = cyc; en[0] = 1'b1;
    exp_q[0].push_back(n + 5);
    for (int k = 1; k <= 4; k++) begin
      step(1);
      check_val($sformatf("t2_count_k%0d", k), cnt_of(0), 16'(k - 1));
    end
    step(2);
    check_val("t2_done", done[0], 1'b1);
    check_val("t2_count_hold", cnt_of(0), 16'd3);
    check_val("t2_status", status[0], 1'b1);
    check_val("t2_irq", irq, 1'b1);
    en[0] = 1'b0;
    step(1);
    check_val("t2_count_idle", cnt_of(0), 16'd0);
    check_val("t2_done_idle", done[0], 1'b0);
    clr_ch(0);

    // 3: ch1 periodic tc=2, then prescale=4 tc=1
    do_load(1, 2);
    periodic[1] = 1'b1;
    n = cyc; en[1] = 1'b1;
    exp_q[1].push_back(n + 4); exp_q[1].push_back(n + 7);
    exp_q[1].push_back(n + 10); exp_q[1].push_back(n + 13);
    seq = '{0, 1, 2, 0, 1, 2};
    for (int k = 1; k <= 6; k++) begin
      step(1);
      check_val($sformatf("t3_count_k%0d", k), cnt_of(1), 16'(seq[k-1]));
    end
    run_to(n + 14);
    prescale = 8'd4;
    load_value[1*CW +: CW] = 16'd1;
    load[1] = 1'b1;
    step(1);
    load[1] = 1'b0;
    exp_q[1].push_back(n + 24); exp_q[1].push_back(n + 34);
    exp_q[1].push_back(n + 44);
    run_to(n + 45);
    load_value[1*CW +: CW] = 16'd7;
    load[1] = 1'b1; periodic[1] = 1'b0; en[1] = 1'b0; prescale = '0;
    step(1);
    load[1] = 1'b0;
    clr_ch(1);

    // 4: ch2 pause/resume and load mid-count
    do_load(2, 5);
    n = cyc; en[2] = 1'b1;
    exp_q[2].push_back(n + 11);
    step(4);
    check_val("t4_count_pre_pause", cnt_of(2), 16'd3);
    en[2] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(1);
      check_val($sformatf("t4_count_paused_%0d", k), cnt_of(2), 16'd3);
    end
    en[2] = 1'b1;
    step(1);
    check_val("t4_count_resume", cnt_of(2), 16'd4);
    step(3);
    en[2] = 1'b0;
    step(1);
    check_val("t4_count_idle", cnt_of(2), 16'd0);
    en[2] = 1'b1;
    step(2);
    check_val("t4_count_before_load", cnt_of(2), 16'd1);
    load_value[2*CW +: CW] = 16'd2;
    load[2] = 1'b1;
    step(1);
    load[2] = 1'b0;
    check_val("t4_count_after_load", cnt_of(2), 16'd0);
    check_val("t4_done_after_load", done[2], 1'b0);
    step(1);
    check_val("t4_idle_arm_no_count", cnt_of(2), 16'd0);
    step(1);
    check_val("t4_count_first_tick", cnt_of(2), 16'd1);
    exp_q[2].push_back(n + 20);
    step(3);
    en[2] = 1'b0;
    step(1);
    clr_ch(2);

    // 5: ch3 tc=0 periodic, clr vs expiry, load vs expiry
    do_load(3, 0);
    periodic[3] = 1'b1;
    n = cyc; en[3] = 1'b1;
    for (int k = 2; k <= 7; k++) exp_q[3].push_back(n + k);
    run_to(n + 4);
    clr[3] = 1'b1;
    step(1);
    clr[3] = 1'b0;
    check_val("t5_set_wins", status[3], 1'b1);
    run_to(n + 7);
    load[3] = 1'b1;
    step(1);
    load[3] = 1'b0; en[3] = 1'b0;
    check_val("t5_load_status_kept", status[3], 1'b1);
    check_val("t5_load_count", cnt_of(3), 16'd0);
    step(1);
    clr[3] = 1'b1;
    step(1);
    clr[3] = 1'b0;
    check_val("t5_status_cleared", status, 4'b0000);
    check_val("t5_irq_low", irq, 1'b0);
    periodic[3] = 1'b0;

    // 6: all channels running, asynchronous reset mid-run
    load_value = {16'd4, 16'd6, 16'd5, 16'd3};
    load = 4'hF; periodic = 4'hF;
    step(1);
    load = '0;
    n = cyc; en = 4'hF;
    exp_q[0].push_back(n + 5);
    run_to(n + 5);
    check_val("t6_count1_running", cnt_of(1), 16'd4);
    check_val("t6_count2_running", cnt_of(2), 16'd4);
    #2 reset = 1'b1;
    #1;
    check_val("t6_async_count", count, '0);
    check_val("t6_async_pulse", pulse, '0);
    check_val("t6_async_status", status, '0);
    check_val("t6_async_irq", irq, 1'b0);
    en = '0; periodic = '0;
    step(2);
    reset = 1'b0;
    step(3);
    check_val("t6_post_count", count, '0);
    check_val("t6_post_done", done, '0);
    n = cyc; en[0] = 1'b1;
    exp_q[0].push_back(n + 9);
    run_to(n + 10);
    check_val("t6_default_tc_restored", cnt_of(0), 16'd7);
    en[0] = 1'b0;
    step(2);

    for (int c = 0; c < NCH; c++)
      check_val($sformatf("pending_pulses_ch%0d", c), exp_q[c].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/timer_bank.md
# timer_bank

Multi-channel, parametrised interval timer. It generalises the fixed 3-bit "count to 7, assert ready" timer into NCH independent channels. Each channel has a loadable terminal count, one-shot or periodic mode, a pause/stop enable, a one-cycle expiry pulse and a sticky status bit. A shared prescaler derives the count tick from `clk`. The block sits beside the control FSMs that need timeouts and retry intervals, and drives a single interrupt line.

## Interface
- `NCH`, 4: number of channels.
- `CW`, 16: counter / terminal-count width.
- `PSW`, 8: prescaler width.
- `DEFAULT_TC`, 7: per-channel terminal count after reset.

Ports:
- `clk` in 1: clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `prescale` in PSW: tick divider; a tick occurs every `prescale`+1 cycles.
- `en` in NCH: per-channel run enable (level).
- `periodic` in NCH: 1 selects auto-reload, 0 selects one-shot.
- `load` in NCH: per-channel load strobe.
- `load_value` in NCH*CW: channel i occupies bits [i*CW +: CW].
- `clr` in NCH: per-channel status clear strobe.
- `count` out NCH*CW: current count of each channel.
- `pulse` out NCH: one-cycle expiry pulse (registered).
- `done` out NCH: one-shot channel parked at terminal count.
- `status` out NCH: sticky expiry flags.
- `irq` out 1: OR of `status`.

## Operation
- **Prescaler:** shared free-running `pre_cnt`.
  - `tick` = (`pre_cnt` >= `prescale`); when `tick` is high, `pre_cnt` returns to 0, otherwise it increments.
  - `prescale`=0 gives a tick every cycle.
  - Lowering `prescale` below the current `pre_cnt` produces an immediate tick, never a wrap through the maximum value.
- **Per-channel registers:** `cnt` (CW), `tc` (CW), state ∈ {IDLE, RUN, DONE}.
- **`load[i]`** has the highest priority in every state:
  - `tc` <= slice; `cnt` <= 0; state <= IDLE.
  - `done[i]` is cleared; no pulse is generated.
- **IDLE:**
  - `cnt`=0.
  - `en[i]`=1 → RUN on the next edge; no count is taken on that edge.
- **RUN:**
  - `en[i]`=0 → hold (pause); `cnt` is frozen.
  - `en[i]`=1 & `tick` & `cnt`<`tc` → `cnt` +1.
  - `en[i]`=1 & `tick` & `cnt`==`tc` → expiry:
    - `pulse[i]`=1 for the following cycle; `status[i]` set.
    - periodic: `cnt` <= 0, stay in RUN.
    - one-shot: `cnt` holds `tc`, go to DONE.
- **DONE:**
  - `done[i]`=1, `cnt`=`tc`.
  - `en[i]`=0 → `cnt` <= 0, IDLE, `done[i]` cleared.
  - `en[i]`=1 → remain in DONE; no further pulses.
- **`tc`=0:** expires on every tick while in RUN; the period is 1 tick.
- **Period:** the periodic period is `tc`+1 ticks.
- **Status register:**
  - `clr[i]` clears `status[i]`.
  - Expiry and `clr` in the same cycle → `status` is set (set wins).
- **`periodic[i]` changes** take effect at the next expiry.
- **Arithmetic:** all count arithmetic is unsigned CW-bit; `cnt` never exceeds `tc`, so no overflow is possible.

## Timing
- **Reset:**
  - `pre_cnt`=0; every `cnt`=0; every `tc`=`DEFAULT_TC`; all states IDLE.
  - `count`=0, `pulse`=0, `done`=0, `status`=0, `irq`=0.
  - Reset asserted mid-run aborts immediately and asynchronously; no pulse is emitted.
- **Registered outputs:** all outputs are registered except `irq`, which is combinational from `status`.
- **Latency with `prescale`=0:** `en` sampled high in IDLE → `pulse` asserted `tc`+2 cycles later.
- **Periodic pulse spacing:** (`tc`+1)·(`prescale`+1) cycles.
- **`pulse` width:** exactly one cycle, even if `en` drops in the same cycle.
- **`load` and expiry in the same cycle:** `load` wins; no pulse, `status` unchanged.
- **Channel independence:** channels are fully independent except for the shared tick.

## Test plan
1. Assert `reset` for 3 cycles, release → every output 0, `count` all 0, internal `tc`=7 on every channel. Then `en[0]`=1 with one-shot and `prescale`=0 → `pulse[0]` 9 cycles after `en` is sampled, followed by `done[0]`=1 and `count0`=7.
2. Ch0 `load_value`=3, one-shot, `prescale`=0, raise `en` → `count0` steps 0,1,2,3; `pulse[0]` high for exactly one cycle, 5 cycles after `en`; `done[0]`=1; `status[0]`=1 and `irq`=1. Drop `en` → `count0`=0, `done`=0.
3. Ch1 periodic with `tc`=2 and `prescale`=0 → `count1` sequence 0,1,2,0,1,2; `pulse[1]` every 3 cycles. Set `prescale`=4 and `tc`=1 → `pulse[1]` every 10 cycles.
4. Ch2 `tc`=5 running: drop `en` at `count`=3 for 4 cycles → `count` holds 3, then resumes at 4. Pulse `load` with value 2 at `count`=1 → `count`=0, state IDLE, no pulse.
5. Ch3 `tc`=0 periodic → `pulse` every cycle. Assert `clr[3]` in an expiry cycle → `status[3]` stays 1. Assert `clr` in a cycle without expiry → `status[3]`=0.
6. All 4 channels running with different `tc` values; assert `reset` mid-run → every output 0 immediately; after release, channels require a fresh `en` to count again.
